decoder_9_to_512_bitmap: RTL
============================

// Module: decoder_9_to_512_bitmap
// PURPOSE
//   Index-to-bitmap writer for the programmable priority encoder datapath. Accepts
//   9-bit index commands (set/clear/toggle/clear-all) over valid/ready. Decodes each
//   index to one-hot and applies it to a registered N-bit request bitmap, which
//   drives encoder_512_to_9. Emits each decoded one-hot as a handshaked event stream.
//   Keeps a population count with empty/full flags.
// PARAMETERS
//   IDX_W  9    index width
//   N      512  bitmap width, N <= 2**IDX_W; CNT_W = $clog2(N+1)
// PORTS
//   clk        in   1      clock; all state on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      command accepted when cmd_valid & cmd_ready
//   cmd_op     in   2      00 SET, 01 CLR, 10 TOGGLE, 11 CLR_ALL (cmd_idx ignored)
//   cmd_idx    in   IDX_W  bit index
//   out_valid  out  1      applied-command event valid
//   out_ready  in   1      downstream accepts event
//   out_onehot out  N      one-hot of the applied index (all-zero for CLR_ALL or error)
//   out_err    out  1      event flags a rejected command
//   bitmap     out  N      current request bitmap (to encoder)
//   count      out  CNT_W  number of set bits in bitmap
//   empty      out  1      count == 0
//   full       out  1      count == N
// BEHAVIOUR
//   - Reset (async, rst_n=0): bitmap=0, count=0, empty=1, full=0, out_valid=0,
//     out_onehot=0, out_err=0, stage-1 valid=0. cmd_ready=1 after reset release.
//     In-flight commands are dropped with no event.
//   - Two stages:
//     S1 registers {op, one-hot(cmd_idx), range_err} on accept.
//     S2 (output register) loads on S1 advance.
//     s1_adv = s1_valid & (~out_valid | out_ready).
//     cmd_ready = ~s1_valid | s1_adv (combinational, no dependence on cmd_valid).
//   - Latency: command accepted at edge T; bitmap, count and out_* updated at edge T+2.
//     Full throughput is 1 command/cycle with out_ready=1.
//   - Apply on s1_adv, using the bitmap value current at that edge:
//     - SET: bit already 1 -> err, no change; else bit<=1, count+1.
//     - CLR: bit already 0 -> err, no change; else bit<=0, count-1.
//     - TOGGLE: always flips; count +/-1 accordingly; never err.
//     - CLR_ALL: bitmap<=0, count<=0, onehot=0, no err.
//     - cmd_idx >= N (only possible when N < 2**IDX_W): err, onehot=0, no change.
//   - On err, out_onehot is 0 and out_err is 1.
//   - Ordering: commands are applied strictly in acceptance order. Back-to-back commands
//     on the same index see each other's effect, because S2 reads the live bitmap.
//   - Backpressure: out_valid & ~out_ready holds out_*, bitmap and count stable. S1 holds,
//     so at most 2 commands are buffered; then cmd_ready=0.
//   - count never wraps: the bitmap checks guarantee 0 <= count <= N.
//     empty and full are registered, updated with count.
//   - cmd_op/cmd_idx are ignored when cmd_valid=0.
// STRUCTURE
//   - Shared package ppe_pkg: localparams OP_SET/OP_CLR/OP_TOGGLE/OP_CLR_ALL (2-bit),
//     IDX_W, N.
//   - Sub-module onehot_decoder (combinational idx -> N-bit one-hot, plus range flag),
//     instantiated in front of S1.
//   - Top holds the S1/S2 registers, bitmap, count, flags and handshake logic.
// TESTING
//   1. Reset: hold rst_n=0 -> bitmap=0, count=0, empty=1, full=0, out_valid=0;
//      after release cmd_ready=1.
//   2. out_ready=1; SET 0, SET 511, SET 300 on consecutive cycles
//      -> out_onehot = 1<<0, 1<<511, 1<<300 at T+2..T+4; final count=3, empty=0.
//   3. SET 5 then SET 5 back-to-back -> second event out_err=1, onehot=0, count stays 1.
//      Then CLR 5 -> count=0; CLR 5 again -> err.
//   4. out_ready=0 with cmd_valid held over 4 commands (SET 1,2,3,4)
//      -> exactly 2 accepted, then cmd_ready=0; bitmap shows only bit 1.
//      Raise out_ready -> events 1,2,3,4 in order; bitmap=0x1E.
//   5. SET all 0..511 -> full=1, count=512. TOGGLE 7 -> count=511, full=0.
//      CLR_ALL -> bitmap=0, count=0, empty=1, out_onehot=0, out_err=0.
//   6. Assert rst_n=0 asynchronously with 2 commands buffered -> outputs clear
//      immediately, before the next edge. No stale event appears after release.

Source files
------------

// File: rtl/ppe_pkg.sv
// Shared constants for the programmable priority encoder datapath:
// index/bitmap widths and the 2-bit command opcodes.
package ppe_pkg;

  localparam int IDX_W = 9;
  localparam int N     = 512;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [1:0] OP_SET     = 2'b00;
  localparam logic [1:0] OP_CLR     = 2'b01;
  localparam logic [1:0] OP_TOGGLE  = 2'b10;
  localparam logic [1:0] OP_CLR_ALL = 2'b11;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational index -> N-bit one-hot decoder.
// Out-of-range indices give an all-zero vector and raise range_err.
module onehot_decoder
  import ppe_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot,
  output logic             range_err
);

  // Decode the index; suppress the one-hot when it falls past the bitmap
  always_comb begin
    onehot    = '0;
    range_err = (32'(idx) >= 32'(N));
    if (!range_err) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_9_to_512_bitmap.sv
// Index-to-bitmap writer: two-stage set/clear/toggle pipeline with
// handshaked one-hot event output and registered population count.
module decoder_9_to_512_bitmap
  import ppe_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_onehot,
  output logic             out_err,
  output logic [N-1:0]     bitmap,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [N-1:0]     dec_onehot;
  logic             dec_err;

  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [N-1:0]     s1_onehot_q, s1_onehot_d;
  logic             s1_err_q, s1_err_d;

  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_onehot_q, out_onehot_d;
  logic             out_err_q, out_err_d;
  logic [N-1:0]     bitmap_q, bitmap_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;

  logic             s1_adv;
  logic             accept;
  logic             hit;

  onehot_decoder u_dec (
    .idx       (cmd_idx),
    .onehot    (dec_onehot),
    .range_err (dec_err)
  );

  // Handshake: S1 drains into S2 whenever the output slot is free or leaving
  always_comb begin
    s1_adv    = s1_valid_q & (~out_valid_q | out_ready);
    cmd_ready = ~s1_valid_q | s1_adv;
    accept    = cmd_valid & cmd_ready;
  end

  // S1 capture: CLR_ALL ignores its index, so it never carries a range error
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_onehot_d = s1_onehot_q;
    s1_err_d    = s1_err_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = cmd_op;
      if (cmd_op == OP_CLR_ALL) begin
        s1_onehot_d = '0;
        s1_err_d    = 1'b0;
      end else begin
        s1_onehot_d = dec_onehot;
        s1_err_d    = dec_err;
      end
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 apply: operate on the live bitmap so back-to-back commands chain
  always_comb begin
    hit          = |(bitmap_q & s1_onehot_q);
    out_valid_d  = out_valid_q & ~out_ready;
    out_onehot_d = out_onehot_q;
    out_err_d    = out_err_q;
    bitmap_d     = bitmap_q;
    count_d      = count_q;
    empty_d      = empty_q;
    full_d       = full_q;
    if (s1_adv) begin
      out_valid_d  = 1'b1;
      out_onehot_d = s1_onehot_q;
      out_err_d    = 1'b0;
      if (s1_err_q) begin
        out_onehot_d = '0;
        out_err_d    = 1'b1;
      end else begin
        unique case (s1_op_q)
          OP_SET: begin
            if (hit) begin
              out_onehot_d = '0;
              out_err_d    = 1'b1;
            end else begin
              bitmap_d = bitmap_q | s1_onehot_q;
              count_d  = count_q + CNT_W'(1);
            end
          end
          OP_CLR: begin
            if (!hit) begin
              out_onehot_d = '0;
              out_err_d    = 1'b1;
            end else begin
              bitmap_d = bitmap_q & ~s1_onehot_q;
              count_d  = count_q - CNT_W'(1);
            end
          end
          OP_TOGGLE: begin
            bitmap_d = bitmap_q ^ s1_onehot_q;
            if (hit) begin
              count_d = count_q - CNT_W'(1);
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
          OP_CLR_ALL: begin
            out_onehot_d = '0;
            bitmap_d     = '0;
            count_d      = '0;
          end
        endcase
      end
      empty_d = (count_d == '0);
      full_d  = (count_d == CNT_W'(N));
    end
  end

  // State registers; reset drops anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= OP_SET;
      s1_onehot_q  <= '0;
      s1_err_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_onehot_q <= '0;
      out_err_q    <= 1'b0;
      bitmap_q     <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_onehot_q  <= s1_onehot_d;
      s1_err_q     <= s1_err_d;
      out_valid_q  <= out_valid_d;
      out_onehot_q <= out_onehot_d;
      out_err_q    <= out_err_d;
      bitmap_q     <= bitmap_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = out_onehot_q;
  assign out_err    = out_err_q;
  assign bitmap     = bitmap_q;
  assign count      = count_q;
  assign empty      = empty_q;
  assign full       = full_q;

endmodule
